idex_stage: RTL and testbench

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage.sv | 211 +++++++++++++++++++++
 tb/tb_idex_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// ----------------------------------------------------------------------------
// idex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded ID-stage instruction, its operands and control bits
// into the ID/EX register. It also owns the stall/flush/hold sequencing for
// the front end of the pipe.
//
// Ports
//   Clk, Rst_n              : clock (rising edge), async active-low reset
//   IFID_Instruction        : raw instruction sitting in IF/ID
//   IFID_PCPlus4            : PC+4 of that instruction
//   ID_ReadData1/2          : register file read data
//   ID_SignExtImm           : sign-extended immediate
//   ID_RegWrite .. ID_ALUOp : decoded control bits
//   Flush                   : squash the ID instruction (taken branch/jump)
//   Hold                    : freeze the whole stage (downstream busy)
//   IDEX_*                  : registered ID/EX contents
//   PCWrite, IFIDWrite      : 1 = PC / IF-ID may advance this cycle
//   StallCount              : saturating count of load-use bubbles
// ----------------------------------------------------------------------------
module idex_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] IFID_Instruction,
    input  logic [31:0] IFID_PCPlus4,
    input  logic [31:0] ID_ReadData1,
    input  logic [31:0] ID_ReadData2,
    input  logic [31:0] ID_SignExtImm,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        ID_MemToReg,
    input  logic        ID_ALUSrc,
    input  logic        ID_RegDst,
    input  logic [3:0]  ID_ALUOp,
    input  logic        Flush,
    input  logic        Hold,
    output logic [31:0] IDEX_Instruction,
    output logic [31:0] IDEX_PCPlus4,
    output logic [31:0] IDEX_ReadData1,
    output logic [31:0] IDEX_ReadData2,
    output logic [31:0] IDEX_SignExtImm,
    output logic [4:0]  IDEX_RegisterRs,
    output logic [4:0]  IDEX_RegisterRt,
    output logic [4:0]  IDEX_RegisterDst,
    output logic        IDEX_RegWrite,
    output logic        IDEX_MemRead,
    output logic        IDEX_MemWrite,
    output logic        IDEX_MemToReg,
    output logic        IDEX_ALUSrc,
    output logic [3:0]  IDEX_ALUOp,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HELD       = 2'd1,
        HELD_FLUSH = 2'd2   // frozen, with a flush owed on release
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] sign_ext_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [3:0]  alu_op;
    } idex_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    state_t      state_q, state_d;
    idex_t       idex_q, idex_d, id_entry;
    logic [15:0] stall_count_q, stall_count_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, dst;
    logic        rt_is_src;
    logic        load_use;

    assign opcode = IFID_Instruction[31:26];
    assign rs     = IFID_Instruction[25:21];
    assign rt     = IFID_Instruction[20:16];
    assign rd     = IFID_Instruction[15:11];

    // rt is only read by R-type, stores and the two compare-branches; for
    // everything else it names a destination and cannot create a hazard.
    always_comb begin
        case (opcode)
            OP_RTYPE, OP_SW, OP_SB, OP_SH, OP_BEQ, OP_BNE: rt_is_src = 1'b1;
            default:                                        rt_is_src = 1'b0;
        endcase
    end

    assign load_use = idex_q.mem_read && (idex_q.rt != 5'd0) &&
                      ((idex_q.rt == rs) || (rt_is_src && (idex_q.rt == rt)));

    always_comb begin
        if (opcode == OP_JAL) begin
            dst = 5'd31;
        end else if (ID_RegDst) begin
            dst = rd;
        end else begin
            dst = rt;
        end
    end

    // Entry for a normally advancing instruction. A write to $zero is
    // dropped here so the forwarding unit never sees $zero as a producer.
    always_comb begin
        id_entry              = '0;
        id_entry.instr        = IFID_Instruction;
        id_entry.pc_plus4     = IFID_PCPlus4;
        id_entry.read_data1   = ID_ReadData1;
        id_entry.read_data2   = ID_ReadData2;
        id_entry.sign_ext_imm = ID_SignExtImm;
        id_entry.rs           = rs;
        id_entry.rt           = rt;
        id_entry.dst          = dst;
        id_entry.reg_write    = ID_RegWrite && (dst != 5'd0);
        id_entry.mem_read     = ID_MemRead;
        id_entry.mem_write    = ID_MemWrite;
        id_entry.mem_to_reg   = ID_MemToReg;
        id_entry.alu_src      = ID_ALUSrc;
        id_entry.alu_op       = ID_ALUOp;
    end

    // Next-state and upstream-enable logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d       = state_q;
        idex_d        = idex_q;
        stall_count_d = stall_count_q;
        PCWrite       = 1'b0;
        IFIDWrite     = 1'b0;

        if (Hold) begin
            // Frozen: a flush seen at any point during the hold is remembered.
            if (Flush || (state_q == HELD_FLUSH)) begin
                state_d = HELD_FLUSH;
            end else begin
                state_d = HELD;
            end
        end else begin
            state_d   = RUN;
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            if (Flush || (state_q == HELD_FLUSH)) begin
                idex_d = '0;
            end else if (load_use) begin
                // Single bubble; the IF/ID instruction re-presents next cycle.
                idex_d    = '0;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                if (stall_count_q != 16'hFFFF) begin
                    stall_count_d = stall_count_q + 16'd1;
                end
            end else begin
                idex_d = id_entry;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= RUN;
            idex_q        <= '0;
            stall_count_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of block ordering.
            state_q       <= state_d;
            idex_q        <= idex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign IDEX_Instruction = idex_q.instr;
    assign IDEX_PCPlus4     = idex_q.pc_plus4;
    assign IDEX_ReadData1   = idex_q.read_data1;
    assign IDEX_ReadData2   = idex_q.read_data2;
    assign IDEX_SignExtImm  = idex_q.sign_ext_imm;
    assign IDEX_RegisterRs  = idex_q.rs;
    assign IDEX_RegisterRt  = idex_q.rt;
    assign IDEX_RegisterDst = idex_q.dst;
    assign IDEX_RegWrite    = idex_q.reg_write;
    assign IDEX_MemRead     = idex_q.mem_read;
    assign IDEX_MemWrite    = idex_q.mem_write;
    assign IDEX_MemToReg    = idex_q.mem_to_reg;
    assign IDEX_ALUSrc      = idex_q.alu_src;
    assign IDEX_ALUOp       = idex_q.alu_op;
    assign StallCount       = stall_count_q;

endmodule

// File: tb/tb_idex_stage.sv
// ----------------------------------------------------------------------------
// tb_idex_stage -- directed, table-driven bench for idex_stage.
// Each table row drives one cycle of ID-stage inputs, checks the upstream
// enables before the edge and the ID/EX register after it. Hand-written
// sequences cover reset, counter saturation and reset during a held flush.
// ----------------------------------------------------------------------------
module tb_idex_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] IFID_Instruction, IFID_PCPlus4;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
    logic        ID_ALUSrc, ID_RegDst;
    logic [3:0]  ID_ALUOp;
    logic        Flush, Hold;
    logic [31:0] IDEX_Instruction, IDEX_PCPlus4;
    logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExtImm;
    logic [4:0]  IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterDst;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg;
    logic        IDEX_ALUSrc;
    logic [3:0]  IDEX_ALUOp;
    logic        PCWrite, IFIDWrite;
    logic [15:0] StallCount;

    idex_stage dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .ID_ReadData1     (ID_ReadData1),
        .ID_ReadData2     (ID_ReadData2),
        .ID_SignExtImm    (ID_SignExtImm),
        .ID_RegWrite      (ID_RegWrite),
        .ID_MemRead       (ID_MemRead),
        .ID_MemWrite      (ID_MemWrite),
        .ID_MemToReg      (ID_MemToReg),
        .ID_ALUSrc        (ID_ALUSrc),
        .ID_RegDst        (ID_RegDst),
        .ID_ALUOp         (ID_ALUOp),
        .Flush            (Flush),
        .Hold             (Hold),
        .IDEX_Instruction (IDEX_Instruction),
        .IDEX_PCPlus4     (IDEX_PCPlus4),
        .IDEX_ReadData1   (IDEX_ReadData1),
        .IDEX_ReadData2   (IDEX_ReadData2),
        .IDEX_SignExtImm  (IDEX_SignExtImm),
        .IDEX_RegisterRs  (IDEX_RegisterRs),
        .IDEX_RegisterRt  (IDEX_RegisterRt),
        .IDEX_RegisterDst (IDEX_RegisterDst),
        .IDEX_RegWrite    (IDEX_RegWrite),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_MemWrite    (IDEX_MemWrite),
        .IDEX_MemToReg    (IDEX_MemToReg),
        .IDEX_ALUSrc      (IDEX_ALUSrc),
        .IDEX_ALUOp       (IDEX_ALUOp),
        .PCWrite          (PCWrite),
        .IFIDWrite        (IFIDWrite),
        .StallCount       (StallCount)
    );

    always #5 Clk = ~Clk;

    // Instruction encodings
    localparam logic [31:0] I_LW    = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] I_LW0   = 32'h8D20_0000; // lw   $0,0($9)
    localparam logic [31:0] I_ADD   = 32'h010B_5020; // add  $10,$8,$11
    localparam logic [31:0] I_ADDRT = 32'h0168_5020; // add  $10,$11,$8
    localparam logic [31:0] I_ADDI  = 32'h2188_0004; // addi $8,$12,4
    localparam logic [31:0] I_ADD0  = 32'h0022_0020; // add  $0,$1,$2
    localparam logic [31:0] I_ADDZ  = 32'h0000_5020; // add  $10,$0,$0
    localparam logic [31:0] I_JAL   = 32'h0C00_0100; // jal  0x100

    // Control: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp}
    localparam logic [9:0] C_LW   = 10'b110110_0000;
    localparam logic [9:0] C_ADD  = 10'b100001_0010;
    localparam logic [9:0] C_ADDI = 10'b100010_0011;
    localparam logic [9:0] C_JAL  = 10'b100000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic        flush;
        logic        hold;
        logic        exp_pcw;
        int          exp_src;   // row whose inputs IDEX must hold; -1 = bubble
        logic [4:0]  exp_dst;
        logic        exp_rw;
        logic [15:0] exp_stall;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [191:0] act,
                         input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] instr, input logic [9:0] ctrl,
                                 input logic flush, input logic hold,
                                 input logic exp_pcw, input int exp_src,
                                 input logic [4:0] exp_dst, input logic exp_rw,
                                 input logic [15:0] exp_stall);
        vec_t v;
        v.instr     = instr;
        v.ctrl      = ctrl;
        v.flush     = flush;
        v.hold      = hold;
        v.exp_pcw   = exp_pcw;
        v.exp_src   = exp_src;
        v.exp_dst   = exp_dst;
        v.exp_rw    = exp_rw;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    // Data operands are tagged with the row number so a stale or wrong
    // capture is visible.
    function automatic logic [137:0] tag_data(input int tag, input logic [31:0] instr);
        logic [31:0] t;
        t = 32'(tag);
        return {32'h0040_0000 + (t << 2), 32'h1000_0000 + t, 32'h2000_0000 + t,
                32'h3000_0000 + t, instr[25:21], instr[20:16]};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [9:0] ctrl,
                         input int tag, input logic flush, input logic hold);
        logic [137:0] d;
        d = tag_data(tag, instr);
        IFID_Instruction = instr;
        IFID_PCPlus4     = d[137:106];
        ID_ReadData1     = d[105:74];
        ID_ReadData2     = d[73:42];
        ID_SignExtImm    = d[41:10];
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst, ID_ALUOp} = ctrl;
        Flush = flush;
        Hold  = hold;
    endtask

    // Drive one cycle, check enables before the edge, leave time at edge+1.
    task automatic step(input string name, input logic [31:0] instr,
                        input logic [9:0] ctrl, input int tag, input logic flush,
                        input logic hold, input logic exp_pcw);
        @(negedge Clk);
        drive(instr, ctrl, tag, flush, hold);
        #1;
        check({name, " pcwrite"}, 192'(PCWrite), 192'(exp_pcw));
        check({name, " ifidwrite"}, 192'(IFIDWrite), 192'(exp_pcw));
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [183:0] all_outputs();
        return {IDEX_Instruction, IDEX_PCPlus4, IDEX_ReadData1, IDEX_ReadData2,
                IDEX_SignExtImm, IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterDst,
                IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg,
                IDEX_ALUSrc, IDEX_ALUOp, StallCount};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  e_instr;
        logic [7:0]   e_ctrl;
        logic [137:0] e_data;
        string        nm;

        //            instr    ctrl    f  h  pcw src dst rw stall
        vecs[0]  = mkv(I_LW,    C_LW,   0, 0, 1,  0,  8, 1, 16'd0);
        vecs[1]  = mkv(I_ADD,   C_ADD,  0, 0, 0, -1,  0, 0, 16'd1); // load-use
        vecs[2]  = mkv(I_ADD,   C_ADD,  0, 0, 1,  2, 10, 1, 16'd1);
        vecs[3]  = mkv(I_LW,    C_LW,   0, 0, 1,  3,  8, 1, 16'd1);
        vecs[4]  = mkv(I_ADDI,  C_ADDI, 0, 0, 1,  4,  8, 1, 16'd1); // rt not a source
        vecs[5]  = mkv(I_LW,    C_LW,   0, 0, 1,  5,  8, 1, 16'd1);
        vecs[6]  = mkv(I_ADD,   C_ADD,  1, 0, 1, -1,  0, 0, 16'd1); // flush beats load-use
        vecs[7]  = mkv(I_ADD0,  C_ADD,  0, 0, 1,  7,  0, 0, 16'd1); // write to $zero
        vecs[8]  = mkv(I_JAL,   C_JAL,  0, 0, 1,  8, 31, 1, 16'd1);
        vecs[9]  = mkv(I_LW,    C_LW,   0, 1, 0,  8, 31, 1, 16'd1); // hold 1
        vecs[10] = mkv(I_LW,    C_LW,   1, 1, 0,  8, 31, 1, 16'd1); // hold 2 + flush
        vecs[11] = mkv(I_LW,    C_LW,   0, 1, 0,  8, 31, 1, 16'd1); // hold 3
        vecs[12] = mkv(I_LW,    C_LW,   0, 0, 1, -1,  0, 0, 16'd1); // owed bubble
        vecs[13] = mkv(I_LW,    C_LW,   0, 0, 1, 13,  8, 1, 16'd1);
        vecs[14] = mkv(I_ADD,   C_ADD,  0, 1, 0, 13,  8, 1, 16'd1); // hazard masked by hold
        vecs[15] = mkv(I_ADD,   C_ADD,  0, 0, 0, -1,  0, 0, 16'd2); // HELD->RUN stalls
        vecs[16] = mkv(I_ADD,   C_ADD,  0, 0, 1, 16, 10, 1, 16'd2);
        vecs[17] = mkv(I_LW,    C_LW,   0, 0, 1, 17,  8, 1, 16'd2);
        vecs[18] = mkv(I_ADDRT, C_ADD,  0, 0, 0, -1,  0, 0, 16'd3); // hazard through rt
        vecs[19] = mkv(I_ADDRT, C_ADD,  0, 0, 1, 19, 10, 1, 16'd3);
        vecs[20] = mkv(I_LW0,   C_LW,   0, 0, 1, 20,  0, 0, 16'd3); // load into $zero
        vecs[21] = mkv(I_ADDZ,  C_ADD,  0, 0, 1, 21, 10, 1, 16'd3); // no hazard on $zero

        // Reset: everything cleared asynchronously, upstream free to advance.
        Rst_n = 1'b1;
        drive(32'h0, 10'h0, 0, 1'b0, 1'b0);
        #1 Rst_n = 1'b0;
        #2;
        check("reset outputs", 192'(all_outputs()), 192'(0));
        check("reset pcwrite", 192'(PCWrite), 192'(1'b1));
        check("reset ifidwrite", 192'(IFIDWrite), 192'(1'b1));
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("v%0d", i);
            step(nm, vecs[i].instr, vecs[i].ctrl, i, vecs[i].flush, vecs[i].hold,
                 vecs[i].exp_pcw);
            if (vecs[i].exp_src < 0) begin
                e_instr = '0;
                e_ctrl  = '0;
                e_data  = '0;
            end else begin
                e_instr = vecs[vecs[i].exp_src].instr;
                e_ctrl  = {vecs[vecs[i].exp_src].ctrl[8:5], vecs[vecs[i].exp_src].ctrl[3:0]};
                e_data  = tag_data(vecs[i].exp_src, e_instr);
            end
            check({nm, " instr"}, 192'(IDEX_Instruction), 192'(e_instr));
            check({nm, " dst"}, 192'(IDEX_RegisterDst), 192'(vecs[i].exp_dst));
            check({nm, " regwrite"}, 192'(IDEX_RegWrite), 192'(vecs[i].exp_rw));
            check({nm, " ctrl"},
                  192'({IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc, IDEX_ALUOp}),
                  192'(e_ctrl));
            check({nm, " data"},
                  192'({IDEX_PCPlus4, IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExtImm,
                        IDEX_RegisterRs, IDEX_RegisterRt}),
                  192'(e_data));
            check({nm, " stallcount"}, 192'(StallCount), 192'(vecs[i].exp_stall));
        end

        // Saturation: preset the counter two hazards below the top.
        @(negedge Clk);
        force dut.stall_count_q = 16'hFFFD;
        #1;
        release dut.stall_count_q;
        #1;
        check("sat preset", 192'(StallCount), 192'(16'hFFFD));
        step("sat lw1", I_LW, C_LW, 100, 1'b0, 1'b0, 1'b1);
        step("sat add1", I_ADD, C_ADD, 101, 1'b0, 1'b0, 1'b0);
        check("sat count1", 192'(StallCount), 192'(16'hFFFE));
        step("sat add1b", I_ADD, C_ADD, 101, 1'b0, 1'b0, 1'b1);
        step("sat lw2", I_LW, C_LW, 102, 1'b0, 1'b0, 1'b1);
        step("sat add2", I_ADD, C_ADD, 103, 1'b0, 1'b0, 1'b0);
        check("sat count2", 192'(StallCount), 192'(16'hFFFF));
        step("sat add2b", I_ADD, C_ADD, 103, 1'b0, 1'b0, 1'b1);
        step("sat lw3", I_LW, C_LW, 104, 1'b0, 1'b0, 1'b1);
        step("sat add3", I_ADD, C_ADD, 105, 1'b0, 1'b0, 1'b0);
        check("sat count3", 192'(StallCount), 192'(16'hFFFF));
        check("sat bubble", 192'(IDEX_Instruction), 192'(0));

        // Reset while frozen with a pending flush: the flush must be dropped.
        step("rh hold", I_LW, C_LW, 110, 1'b1, 1'b1, 1'b0);
        #2 Rst_n = 1'b0;
        #1;
        check("rh outputs", 192'(all_outputs()), 192'(0));
        Hold = 1'b0;
        #1;
        check("rh pcwrite", 192'(PCWrite), 192'(1'b1));
        check("rh ifidwrite", 192'(IFIDWrite), 192'(1'b1));
        @(negedge Clk);
        drive(I_ADD, C_ADD, 111, 1'b0, 1'b0);
        Rst_n = 1'b1;
        #1;
        check("rh add pcwrite", 192'(PCWrite), 192'(1'b1));
        @(posedge Clk);
        #1;
        check("rh add instr", 192'(IDEX_Instruction), 192'(I_ADD));
        check("rh add dst", 192'(IDEX_RegisterDst), 192'(5'd10));
        check("rh stallcount", 192'(StallCount), 192'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
